// File: rtl/fetch_pair_buffer.sv
// Dual-issue fetch stage: drives a PC pair to both imem ports and queues the returned words for decode.
// Optional starvation counter is enabled by defining FETCH_PERF_COUNTER_EN.
`timescale 1ns/1ps
module fetch_pair_buffer #(
   parameter int              DEPTH    = 8,
   parameter int              AW       = 12,
   parameter logic [AW-1:0]   RESET_PC = '0
) (
   input  logic                     clock,
   input  logic                     reset,
   output logic [AW-1:0]            address_imem_1,
   output logic [AW-1:0]            address_imem_2,
   input  logic [31:0]              q_imem_1,
   input  logic [31:0]              q_imem_2,
   input  logic [1:0]               pop,
   input  logic                     redirect,
   input  logic [AW-1:0]            redirect_pc,
   output logic                     out_valid_1,
   output logic                     out_valid_2,
   output logic [31:0]              out_insn_1,
   output logic [31:0]              out_insn_2,
   output logic [AW-1:0]            out_pc_1,
   output logic [AW-1:0]            out_pc_2,
   output logic [$clog2(DEPTH):0]   d_count,
   output logic [31:0]              perf_starve_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FETCH_LIMIT = CW'(DEPTH - 2);

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [31:0]   insn;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic [AW-1:0]   fetch_pc_q, fetch_pc_d;

   logic            fetch_en;
   logic [CW-1:0]   pop_req;
   logic [CW-1:0]   eff_pop;
   logic [PW-1:0]   tail_p1, head_p1;

   assign tail_p1 = tail_q + PW'(1);
   assign head_p1 = head_q + PW'(1);

   // Fetch decision uses the pre-pop occupancy so a full queue never overflows on a simultaneous pop.
   always_comb begin
      fetch_en = (count_q <= FETCH_LIMIT) && !redirect;
      pop_req  = (pop == 2'd3) ? CW'(2) : CW'(pop);
      eff_pop  = (pop_req > count_q) ? count_q : pop_req;

      mem_d      = mem_q;
      head_d     = head_q + eff_pop[PW-1:0];
      tail_d     = tail_q;
      count_d    = count_q - eff_pop;
      fetch_pc_d = fetch_pc_q;

      if (fetch_en) begin
         mem_d[tail_q]  = '{pc: fetch_pc_q,          insn: q_imem_1};
         mem_d[tail_p1] = '{pc: fetch_pc_q + AW'(1), insn: q_imem_2};
         tail_d         = tail_q + PW'(2);
         count_d        = count_d + CW'(2);
         fetch_pc_d     = fetch_pc_q + AW'(2);
      end

      if (redirect) begin
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         fetch_pc_d = redirect_pc;
      end
   end

   // NOTE: storage is reset along with the pointers because out_insn/out_pc must read zero after reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         fetch_pc_q <= RESET_PC;
      end else begin
         mem_q      <= mem_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   assign address_imem_1 = fetch_pc_q;
   assign address_imem_2 = fetch_pc_q + AW'(1);
   assign out_valid_1    = (count_q != '0);
   assign out_valid_2    = (count_q >= CW'(2));
   assign out_insn_1     = mem_q[head_q].insn;
   assign out_insn_2     = mem_q[head_p1].insn;
   assign out_pc_1       = mem_q[head_q].pc;
   assign out_pc_2       = mem_q[head_p1].pc;
   assign d_count        = count_q;

`ifdef FETCH_PERF_COUNTER_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (!out_valid_1 && !redirect && (perf_q != '1)) perf_d = perf_q + 32'd1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) perf_q <= '0;
      else        perf_q <= perf_d;
   end

   assign perf_starve_cnt = perf_q;
`else
   assign perf_starve_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_pair_buffer.sv
// Directed bench for fetch_pair_buffer; imem modelled as word(addr) = 0x10 + addr.
`timescale 1ns/1ps
module tb_fetch_pair_buffer;

   localparam int DEPTH = 8;
   localparam int AW    = 12;

   logic          clock = 1'b0;
   logic          reset;
   logic [AW-1:0] address_imem_1, address_imem_2;
   logic [31:0]   q_imem_1, q_imem_2;
   logic [1:0]    pop;
   logic          redirect;
   logic [AW-1:0] redirect_pc;
   logic          out_valid_1, out_valid_2;
   logic [31:0]   out_insn_1, out_insn_2;
   logic [AW-1:0] out_pc_1, out_pc_2;
   logic [3:0]    d_count;
   logic [31:0]   perf_starve_cnt;

   int checks   = 0;
   int failures = 0;

`ifdef FETCH_PERF_COUNTER_EN
   localparam logic [31:0] PERF_ONE = 32'd1;
`else
   localparam logic [31:0] PERF_ONE = 32'd0;
`endif

   fetch_pair_buffer #(.DEPTH(DEPTH), .AW(AW), .RESET_PC('0)) dut (
      .clock           (clock),
      .reset           (reset),
      .address_imem_1  (address_imem_1),
      .address_imem_2  (address_imem_2),
      .q_imem_1        (q_imem_1),
      .q_imem_2        (q_imem_2),
      .pop             (pop),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .out_valid_1     (out_valid_1),
      .out_valid_2     (out_valid_2),
      .out_insn_1      (out_insn_1),
      .out_insn_2      (out_insn_2),
      .out_pc_1        (out_pc_1),
      .out_pc_2        (out_pc_2),
      .d_count         (d_count),
      .perf_starve_cnt (perf_starve_cnt)
   );

   always #5 clock = ~clock;

   assign q_imem_1 = 32'h10 + {20'd0, address_imem_1};
   assign q_imem_2 = 32'h10 + {20'd0, address_imem_2};

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset       = 1'b0;
      pop         = 2'd0;
      redirect    = 1'b0;
      redirect_pc = '0;
      #3;
      check("rst_count", 64'(d_count), 64'd0);
      check("rst_valid", 64'({out_valid_1, out_valid_2}), 64'd0);
      check("rst_insn1", 64'(out_insn_1), 64'd0);
      check("rst_pc2", 64'(out_pc_2), 64'd0);
      check("rst_addr1", 64'(address_imem_1), 64'd0);
      check("rst_addr2", 64'(address_imem_2), 64'd1);
      check("rst_perf", 64'(perf_starve_cnt), 64'd0);
      reset = 1'b1;

      // first edge after release pushes pc 0/1
      step();
      check("e1_count", 64'(d_count), 64'd2);
      check("e1_insn1", 64'(out_insn_1), 64'h10);
      check("e1_insn2", 64'(out_insn_2), 64'h11);
      check("e1_pc2", 64'(out_pc_2), 64'd1);
      check("e1_valid", 64'({out_valid_1, out_valid_2}), 64'd3);
      check("e1_addr1", 64'(address_imem_1), 64'd2);
      check("e1_perf", 64'(perf_starve_cnt), 64'(PERF_ONE));

      step(); step(); step();
      check("fill_count", 64'(d_count), 64'd8);
      check("fill_addr1", 64'(address_imem_1), 64'd8);
      step();
      check("full_hold_count", 64'(d_count), 64'd8);
      check("full_hold_addr1", 64'(address_imem_1), 64'd8);
      check("full_perf", 64'(perf_starve_cnt), 64'(PERF_ONE));

      // full queue with pop=2: no push this edge, push on the next
      pop = 2'd2;
      step();
      check("fullpop_count", 64'(d_count), 64'd6);
      check("fullpop_addr1", 64'(address_imem_1), 64'd8);
      check("fullpop_pc1", 64'(out_pc_1), 64'd2);
      check("fullpop_insn1", 64'(out_insn_1), 64'h12);
      pop = 2'd0;
      step();
      check("refill_count", 64'(d_count), 64'd8);
      check("refill_addr1", 64'(address_imem_1), 64'd10);

      // pop=3 behaves as 2
      pop = 2'd3;
      step();
      check("pop3a_count", 64'(d_count), 64'd6);
      check("pop3a_pc1", 64'(out_pc_1), 64'd4);
      step();
      check("pop3b_count", 64'(d_count), 64'd6);
      check("pop3b_pc1", 64'(out_pc_1), 64'd6);

      // single pops: push+pop gives 7, then 7 is above the fetch limit
      pop = 2'd1;
      step();
      check("pop1a_count", 64'(d_count), 64'd7);
      check("pop1a_pc1", 64'(out_pc_1), 64'd7);
      step();
      check("pop1b_count", 64'(d_count), 64'd6);
      check("pop1b_pc1", 64'(out_pc_1), 64'd8);
      check("pop1b_addr1", 64'(address_imem_1), 64'd14);

      // redirect with count=6 and pop=2
      pop         = 2'd2;
      redirect    = 1'b1;
      redirect_pc = 12'h0F0;
      step();
      check("redir_count", 64'(d_count), 64'd0);
      check("redir_valid", 64'({out_valid_1, out_valid_2}), 64'd0);
      check("redir_addr1", 64'(address_imem_1), 64'h0F0);
      check("redir_addr2", 64'(address_imem_2), 64'h0F1);
      redirect = 1'b0;
      pop      = 2'd0;
      step();
      check("redir2_pc1", 64'(out_pc_1), 64'h0F0);
      check("redir2_pc2", 64'(out_pc_2), 64'h0F1);
      check("redir2_insn1", 64'(out_insn_1), 64'h100);
      check("redir2_insn2", 64'(out_insn_2), 64'h101);
      check("redir2_count", 64'(d_count), 64'd2);

      // steady pop=2: no bubbles
      pop = 2'd2;
      step();
      check("steady1_pc1", 64'(out_pc_1), 64'h0F2);
      check("steady1_count", 64'(d_count), 64'd2);
      step();
      check("steady2_pc1", 64'(out_pc_1), 64'h0F4);
      check("steady2_valid", 64'({out_valid_1, out_valid_2}), 64'd3);

      // redirect to top of address space; pop=3 on empty queue clamps to 0
      redirect    = 1'b1;
      redirect_pc = 12'hFFF;
      step();
      check("wrap_redir_count", 64'(d_count), 64'd0);
      check("wrap_addr2", 64'(address_imem_2), 64'h000);
      redirect = 1'b0;
      pop      = 2'd3;
      step();
      check("wrap_count", 64'(d_count), 64'd2);
      check("wrap_pc1", 64'(out_pc_1), 64'hFFF);
      check("wrap_pc2", 64'(out_pc_2), 64'h000);
      check("wrap_insn1", 64'(out_insn_1), 64'h100F);
      check("wrap_insn2", 64'(out_insn_2), 64'h10);
      check("wrap_addr1", 64'(address_imem_1), 64'h001);

      // async reset mid-cycle clears before the next edge
      pop = 2'd0;
      step();
      check("pre_rst_count", 64'(d_count), 64'd4);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_count", 64'(d_count), 64'd0);
      check("mid_rst_valid", 64'({out_valid_1, out_valid_2}), 64'd0);
      check("mid_rst_insn1", 64'(out_insn_1), 64'd0);
      check("mid_rst_pc1", 64'(out_pc_1), 64'd0);
      check("mid_rst_addr1", 64'(address_imem_1), 64'd0);
      check("mid_rst_addr2", 64'(address_imem_2), 64'd1);
      check("mid_rst_perf", 64'(perf_starve_cnt), 64'd0);
      #1;
      reset = 1'b1;
      step();
      check("post_rst_count", 64'(d_count), 64'd2);
      check("post_rst_insn1", 64'(out_insn_1), 64'h10);
      check("post_rst_perf", 64'(perf_starve_cnt), 64'(PERF_ONE));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
